// File: rtl/line_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_fetch_ctrl
// Purpose  : Fetches one display line of RGB888 pixels from a PSRAM
//            framebuffer into a line buffer. A rising edge on line_req starts
//            the fetch. The line is read as a series of bursts, with at most
//            BURST_LEN words per burst. Each returned beat is written to the
//            line buffer at its pixel index.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_psram                       : sole clock, rising edge
//   rst_n                           : asynchronous active-low reset
//   line_req / line_idx             : fetch request (level) / line number
//   enable                          : gates the start of new fetches
//   clr_err                         : clears the sticky overrun flag
//   rd_cmd_valid / rd_cmd_ready     : PSRAM read command handshake
//   rd_cmd_addr / rd_cmd_len        : burst start word address / length
//   rd_data_valid / rd_data         : returned pixel beat
//   wr_addr / wr_data / wr_en       : line-buffer write port (registered)
//   busy / line_done / overrun      : status outputs
// ============================================================================
module line_fetch_ctrl #(
  parameter int          H_ACTIVE    = 800,
  parameter int          V_ACTIVE    = 480,
  parameter int          BURST_LEN   = 32,
  parameter logic [21:0] FB_BASE     = 22'd0,
  parameter int          LINE_STRIDE = 1024
) (
  input  logic        clk_psram,
  input  logic        rst_n,
  input  logic        line_req,
  input  logic [9:0]  line_idx,
  input  logic        enable,
  input  logic        clr_err,
  output logic        rd_cmd_valid,
  input  logic        rd_cmd_ready,
  output logic [21:0] rd_cmd_addr,
  output logic [5:0]  rd_cmd_len,
  input  logic        rd_data_valid,
  input  logic [23:0] rd_data,
  output logic [9:0]  wr_addr,
  output logic [23:0] wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        line_done,
  output logic        overrun
);

  localparam int                 PIX_W     = $clog2(H_ACTIVE + 1);
  localparam logic [PIX_W-1:0]   c_h_total = PIX_W'(H_ACTIVE);
  localparam logic [PIX_W-1:0]   c_h_last  = PIX_W'(H_ACTIVE - 1);
  localparam logic [PIX_W-1:0]   c_burst_p = PIX_W'(BURST_LEN);
  localparam logic [5:0]         c_burst   = 6'(BURST_LEN);
  localparam logic [10:0]        c_v_lines = 11'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               req_prev_q;
  logic [9:0]         line_q, line_d;
  logic [PIX_W-1:0]   burst_q, burst_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [5:0]         beat_q, beat_d;
  logic [21:0]        cmd_addr_q, cmd_addr_d;
  logic [5:0]         cmd_len_q, cmd_len_d;
  logic               wr_en_q, wr_en_d;
  logic [9:0]         wr_addr_q, wr_addr_d;
  logic [23:0]        wr_data_q, wr_data_d;
  logic               overrun_q, overrun_d;

  logic               req_rise;
  logic               in_range;
  logic               load_cmd;
  logic [PIX_W-1:0]   remain;

  assign req_rise = line_req & ~req_prev_q;
  assign in_range = ({1'b0, line_idx} < c_v_lines);

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    burst_d    = burst_q;
    pix_d      = pix_q;
    beat_d     = beat_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    load_cmd   = 1'b0;
    remain     = '0;
    overrun_d  = overrun_q;

    if (clr_err) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req_rise && enable && in_range) begin
          state_d  = S_CMD;
          line_d   = line_idx;
          burst_d  = '0;
          pix_d    = '0;
          beat_d   = '0;
          load_cmd = 1'b1;
        end
      end
      S_CMD: begin
        if (rd_cmd_ready) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
      S_DATA: begin
        if (rd_data_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 10'(pix_q);
          wr_data_d = rd_data;
          pix_d     = pix_q + PIX_W'(1);
          beat_d    = beat_q + 6'd1;
          // The last pixel ends the line even if the burst had spare length.
          if (pix_q == c_h_last) begin
            state_d = S_DONE;
          end else if ((beat_q + 6'd1) == cmd_len_q) begin
            state_d  = S_CMD;
            burst_d  = burst_q + PIX_W'(1);
            load_cmd = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A request during DONE also counts as busy. Setting the flag after the
    // clear lets a new event win over clr_err in the same cycle.
    if (req_rise && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    // Address and length are captured once on entry to CMD. They stay
    // stable while the command waits for ready.
    if (load_cmd) begin
      remain     = c_h_total - pix_d;
      cmd_addr_d = FB_BASE
                 + (22'(line_d) * 22'(LINE_STRIDE))
                 + (22'(burst_d) * 22'(BURST_LEN));
      cmd_len_d  = (remain > c_burst_p) ? c_burst : 6'(remain);
    end
  end

  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_prev_q <= 1'b1;
      line_q     <= '0;
      burst_q    <= '0;
      pix_q      <= '0;
      beat_q     <= '0;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= line_req;
      line_q     <= line_d;
      burst_q    <= burst_d;
      pix_q      <= pix_d;
      beat_q     <= beat_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_len_q  <= cmd_len_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rd_cmd_valid = (state_q == S_CMD);
  assign rd_cmd_addr  = cmd_addr_q;
  assign rd_cmd_len   = cmd_len_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = (state_q != S_IDLE);
  assign line_done    = (state_q == S_DONE);
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_line_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_fetch_ctrl
// Purpose  : Directed bench for line_fetch_ctrl. Instance 0 uses the default
//            parameters. Instance 1 uses H_ACTIVE=100, which gives a short
//            final burst. A PSRAM responder returns each burst two cycles
//            after the command is accepted.
// Revision : 1.0  initial release
// ============================================================================
module tb_line_fetch_ctrl;

  localparam int c_bl     = 32;
  localparam int c_stride = 1024;

  logic        clk_psram = 1'b0;
  logic        rst_n;
  logic        line_req      [2];
  logic [9:0]  line_idx      [2];
  logic        enable        [2];
  logic        clr_err       [2];
  logic        rd_cmd_valid  [2];
  logic        rd_cmd_ready  [2];
  logic [21:0] rd_cmd_addr   [2];
  logic [5:0]  rd_cmd_len    [2];
  logic        rd_data_valid [2];
  logic [23:0] rd_data       [2];
  logic [9:0]  wr_addr       [2];
  logic [23:0] wr_data       [2];
  logic        wr_en         [2];
  logic        busy          [2];
  logic        line_done     [2];
  logic        overrun       [2];

  int   total = 0;
  int   bad   = 0;
  int   hpix     [2] = '{800, 100};
  int   exp_line [2];
  int   cmd_n    [2];
  int   wr_n     [2];
  int   done_n   [2];
  int   last_wa  [2];
  int   rsp_dly  [2];
  int   rsp_left [2];
  int   rsp_pix  [2];
  logic stray    [2];

  always #5 clk_psram = ~clk_psram;

  line_fetch_ctrl u_dut0 (
    .clk_psram(clk_psram), .rst_n(rst_n),
    .line_req(line_req[0]), .line_idx(line_idx[0]), .enable(enable[0]), .clr_err(clr_err[0]),
    .rd_cmd_valid(rd_cmd_valid[0]), .rd_cmd_ready(rd_cmd_ready[0]),
    .rd_cmd_addr(rd_cmd_addr[0]), .rd_cmd_len(rd_cmd_len[0]),
    .rd_data_valid(rd_data_valid[0]), .rd_data(rd_data[0]),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_en(wr_en[0]),
    .busy(busy[0]), .line_done(line_done[0]), .overrun(overrun[0])
  );

  line_fetch_ctrl #(.H_ACTIVE(100)) u_dut1 (
    .clk_psram(clk_psram), .rst_n(rst_n),
    .line_req(line_req[1]), .line_idx(line_idx[1]), .enable(enable[1]), .clr_err(clr_err[1]),
    .rd_cmd_valid(rd_cmd_valid[1]), .rd_cmd_ready(rd_cmd_ready[1]),
    .rd_cmd_addr(rd_cmd_addr[1]), .rd_cmd_len(rd_cmd_len[1]),
    .rd_data_valid(rd_data_valid[1]), .rd_data(rd_data[1]),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_en(wr_en[1]),
    .busy(busy[1]), .line_done(line_done[1]), .overrun(overrun[1])
  );

  function automatic logic [23:0] pix_data(input int p);
    logic [9:0] v;
    v = p[9:0];
    return {4'hC, v, ~v};
  endfunction

  function automatic int exp_len(input int h, input int k);
    int r;
    r = h - k * c_bl;
    return (r > c_bl) ? c_bl : r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_psram);
    #1;
  endtask

  task automatic clear_model(input int d, input int line);
    exp_line[d] = line;
    cmd_n[d]    = 0;
    wr_n[d]     = 0;
    done_n[d]   = 0;
    last_wa[d]  = -1;
    rsp_dly[d]  = 0;
    rsp_left[d] = 0;
    rsp_pix[d]  = 0;
  endtask

  task automatic wait_done(input int d, input int limit);
    int c;
    c = 0;
    while (done_n[d] == 0 && c < limit) begin
      tick(1);
      c++;
    end
    check($sformatf("line_done_seen%0d", d), done_n[d], 1);
    tick(3);
  endtask

  // PSRAM responder: data starts two cycles after each accepted command.
  initial begin
    forever begin
      @(negedge clk_psram);
      for (int d = 0; d < 2; d++) begin
        rd_data_valid[d] = stray[d];
        rd_data[d]       = 24'hDEAD00;
        if (rsp_dly[d] > 0) rsp_dly[d]--;
        if (rsp_dly[d] == 0 && rsp_left[d] > 0) begin
          rd_data_valid[d] = 1'b1;
          rd_data[d]       = pix_data(rsp_pix[d]);
          rsp_pix[d]++;
          rsp_left[d]--;
        end
        if (rd_cmd_valid[d] === 1'b1 && rd_cmd_ready[d] === 1'b1) begin
          rsp_dly[d]  = 2;
          rsp_left[d] = int'(rd_cmd_len[d]);
        end
      end
    end
  end

  // Output monitor: checks every accepted command and every line-buffer write.
  initial begin
    forever begin
      @(negedge clk_psram);
      for (int m = 0; m < 2; m++) begin
        if (rd_cmd_valid[m] === 1'b1 && rd_cmd_ready[m] === 1'b1) begin
          check($sformatf("cmd_addr%0d_k%0d", m, cmd_n[m]), rd_cmd_addr[m],
                exp_line[m] * c_stride + cmd_n[m] * c_bl);
          check($sformatf("cmd_len%0d_k%0d", m, cmd_n[m]), rd_cmd_len[m],
                exp_len(hpix[m], cmd_n[m]));
          cmd_n[m]++;
        end
        if (wr_en[m] === 1'b1) begin
          check($sformatf("wr_addr%0d", m), wr_addr[m], wr_n[m]);
          check($sformatf("wr_data%0d", m), wr_data[m], pix_data(wr_n[m]));
          last_wa[m] = int'(wr_addr[m]);
          wr_n[m]++;
        end
        if (line_done[m] === 1'b1) done_n[m]++;
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      line_req[i]     = 1'b0;
      line_idx[i]     = 10'd0;
      enable[i]       = 1'b1;
      clr_err[i]      = 1'b0;
      rd_cmd_ready[i] = 1'b1;
      stray[i]        = 1'b0;
      clear_model(i, 0);
    end
    tick(2);
    check("rst_cmd_valid", rd_cmd_valid[0], 0);
    check("rst_cmd_addr",  rd_cmd_addr[0],  0);
    check("rst_cmd_len",   rd_cmd_len[0],   0);
    check("rst_wr_en",     wr_en[0],        0);
    check("rst_wr_addr",   wr_addr[0],      0);
    check("rst_wr_data",   wr_data[0],      0);
    check("rst_busy",      busy[0],         0);
    check("rst_line_done", line_done[0],    0);
    check("rst_overrun",   overrun[0],      0);
    rst_n = 1'b1;
    tick(2);

    // Full line 5: 25 bursts of 32 words starting at 5120.
    clear_model(0, 5);
    line_idx[0] = 10'd5;
    line_req[0] = 1'b1;
    tick(1);
    check("l5_busy",  busy[0],         1);
    check("l5_valid", rd_cmd_valid[0], 1);
    check("l5_addr0", rd_cmd_addr[0],  5120);
    check("l5_len0",  rd_cmd_len[0],   32);
    wait_done(0, 3000);
    check("l5_cmds",    cmd_n[0],   25);
    check("l5_writes",  wr_n[0],    800);
    check("l5_done_n",  done_n[0],  1);
    check("l5_last_wa", last_wa[0], 799);
    check("l5_busy_end", busy[0],   0);
    check("l5_overrun", overrun[0], 0);
    line_req[0] = 1'b0;
    tick(1);

    // Ready held low: command stays stable. A second edge mid-fetch sets overrun.
    clear_model(0, 7);
    rd_cmd_ready[0] = 1'b0;
    line_idx[0]     = 10'd7;
    line_req[0]     = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      check("stall_addr", rd_cmd_addr[0], 7168);
      check("stall_len",  rd_cmd_len[0],  32);
      check("stall_busy", busy[0],        1);
      tick(1);
    end
    check("stall_no_cmd", cmd_n[0], 0);
    rd_cmd_ready[0] = 1'b1;
    tick(60);
    line_req[0] = 1'b0;
    line_idx[0] = 10'd3;
    tick(1);
    line_req[0] = 1'b1;
    tick(1);
    check("ovr_set",  overrun[0], 1);
    check("ovr_busy", busy[0],    1);
    wait_done(0, 3000);
    check("ovr_cmds",   cmd_n[0],   25);
    check("ovr_writes", wr_n[0],    800);
    check("ovr_done_n", done_n[0],  1);
    check("ovr_held",   overrun[0], 1);
    clr_err[0] = 1'b1;
    tick(1);
    clr_err[0] = 1'b0;
    check("ovr_cleared", overrun[0], 0);
    line_req[0] = 1'b0;
    tick(1);

    // Edges that must be ignored: line out of range, enable low, stray data.
    clear_model(0, 0);
    line_idx[0] = 10'd480;
    line_req[0] = 1'b1;
    tick(3);
    check("oor_busy",  busy[0],         0);
    check("oor_valid", rd_cmd_valid[0], 0);
    line_req[0] = 1'b0;
    tick(1);
    line_idx[0] = 10'd2;
    enable[0]   = 1'b0;
    line_req[0] = 1'b1;
    tick(3);
    check("dis_busy", busy[0],  0);
    check("dis_cmds", cmd_n[0], 0);
    line_req[0] = 1'b0;
    enable[0]   = 1'b1;
    stray[0]    = 1'b1;
    tick(4);
    stray[0]    = 1'b0;
    tick(2);
    check("stray_writes", wr_n[0],    0);
    check("ign_overrun",  overrun[0], 0);

    // Edge in the DONE cycle counts as busy and is discarded.
    clear_model(0, 1);
    line_idx[0] = 10'd1;
    line_req[0] = 1'b1;
    tick(1);
    line_req[0] = 1'b0;
    c = 0;
    while (line_done[0] !== 1'b1 && c < 3000) begin
      tick(1);
      c++;
    end
    check("done_reached", line_done[0], 1);
    line_req[0] = 1'b1;
    tick(1);
    check("done_edge_ovr",  overrun[0], 1);
    check("done_edge_busy", busy[0],    0);
    tick(5);
    check("done_edge_cmds", cmd_n[0],   25);
    check("done_edge_idle", busy[0],    0);
    clr_err[0]  = 1'b1;
    line_req[0] = 1'b0;
    tick(1);
    clr_err[0]  = 1'b0;

    // Reset mid-DATA with line_req high at release.
    clear_model(0, 9);
    line_idx[0] = 10'd9;
    line_req[0] = 1'b1;
    tick(1);
    c = 0;
    while (wr_n[0] < 40 && c < 500) begin
      tick(1);
      c++;
    end
    check("mid_data_reached", wr_n[0] >= 40, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  busy[0],         0);
    check("arst_valid", rd_cmd_valid[0], 0);
    check("arst_wr_en", wr_en[0],        0);
    check("arst_waddr", wr_addr[0],      0);
    check("arst_addr",  rd_cmd_addr[0],  0);
    clear_model(0, 9);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("post_rst_busy",   busy[0],  0);
    check("post_rst_cmds",   cmd_n[0], 0);
    check("post_rst_writes", wr_n[0],  0);
    line_req[0] = 1'b0;
    tick(1);
    line_req[0] = 1'b1;
    tick(1);
    check("refetch_busy", busy[0],        1);
    check("refetch_addr", rd_cmd_addr[0], 9216);
    wait_done(0, 3000);
    check("refetch_writes", wr_n[0], 800);
    line_req[0] = 1'b0;

    // Short line on instance 1: lengths 32, 32, 32, 4.
    clear_model(1, 0);
    line_idx[1] = 10'd0;
    line_req[1] = 1'b1;
    tick(1);
    check("h100_busy", busy[1],       1);
    check("h100_len0", rd_cmd_len[1], 32);
    wait_done(1, 1000);
    check("h100_cmds",    cmd_n[1],   4);
    check("h100_writes",  wr_n[1],    100);
    check("h100_last_wa", last_wa[1], 99);
    check("h100_done_n",  done_n[1],  1);
    line_req[1] = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
